// File: rtl/comp_mult_pkg.sv
// Shared types for the complex-multiplier scheduler: requester tag, FSM states, multiplier latency.
package comp_mult_pkg;

  localparam int CMULT_LATENCY = 4;
  localparam int MAX_REQ       = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } sched_st_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
    logic    last;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping; one-hot grant plus encoded ID.
// Purely combinational, no state.
module rr_arbiter
  import comp_mult_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                gnt_vld
);

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && req[(int'(ptr) + i) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_WIDTH'((int'(ptr) + i) % NUM_REQ);
      end
    end
    if (gnt_vld) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/comp_mult_sched.sv
// Shares one pipelined complex multiplier among NUM_REQ requesters; transfer -> o_rsp_valid in MULT_LATENCY+2 cycles.
// Requesters are held off via one-hot o_req_ready; multiplier and responses have no backpressure.
// Optional CMULT_SCHED_STATS_EN adds o_grant_cnt: saturating 16-bit per-requester grant counters.
module comp_mult_sched
  import comp_mult_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IN_WIDTH_I   = 18,
  parameter int IN_WIDTH_II  = 18,
  parameter int OUT_WIDTH    = 18,
  parameter int MULT_LATENCY = CMULT_LATENCY,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_last,
  input  logic [NUM_REQ*IN_WIDTH_I-1:0]   i_req_a,
  input  logic [NUM_REQ*IN_WIDTH_I-1:0]   i_req_b,
  input  logic [NUM_REQ*IN_WIDTH_II-1:0]  i_req_c,
  input  logic [NUM_REQ*IN_WIDTH_II-1:0]  i_req_d,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [IN_WIDTH_I-1:0]           o_mult_a,
  output logic [IN_WIDTH_I-1:0]           o_mult_b,
  output logic [IN_WIDTH_II-1:0]          o_mult_c,
  output logic [IN_WIDTH_II-1:0]          o_mult_d,
  output logic                            o_mult_valid,
  input  logic [OUT_WIDTH-1:0]            i_mult_r,
  input  logic [OUT_WIDTH-1:0]            i_mult_im,
  input  logic                            i_mult_valid,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [OUT_WIDTH-1:0]            o_rsp_r,
  output logic [OUT_WIDTH-1:0]            o_rsp_im,
  output logic                            o_rsp_last,
  output logic                            o_err_sync
`ifdef CMULT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]           o_grant_cnt
`endif
);

  sched_st_t           st_q, st_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_WIDTH-1:0] arb_id;
  logic                arb_vld;
  logic                xfer;
  logic [ID_WIDTH-1:0] xfer_id;
  logic                xfer_last;

  tag_t                iss_tag_q;
  tag_t                tag_q [MULT_LATENCY];
  tag_t                tag_out;
  logic                rsp_hit;
  logic [NUM_REQ-1:0]  rsp_onehot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_arb (
    .req    (i_req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .gnt_vld(arb_vld)
  );

  always_comb begin
    st_d        = st_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    o_req_ready = '0;
    xfer_id     = arb_id;
    case (st_q)
      ST_IDLE: begin
        o_req_ready = arb_vld ? arb_gnt : '0;
        xfer_id     = arb_id;
      end
      ST_LOCK: begin
        // Ready stays on the locked requester even while it idles, so bubbles block everyone else.
        o_req_ready[lock_id_q] = 1'b1;
        xfer_id                = lock_id_q;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
    xfer      = |(i_req_valid & o_req_ready);
    xfer_last = i_req_last[xfer_id];
    if (xfer) begin
      if (xfer_last) begin
        st_d     = ST_IDLE;
        rr_ptr_d = (xfer_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : xfer_id + 1'b1;
      end else begin
        st_d      = ST_LOCK;
        lock_id_d = xfer_id;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q      <= ST_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      st_q      <= st_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mult_a  <= '0;
      o_mult_b  <= '0;
      o_mult_c  <= '0;
      o_mult_d  <= '0;
      iss_tag_q <= '0;
    end else begin
      iss_tag_q <= '{vld: xfer, id: req_id_t'(xfer_id), last: xfer_last};
      if (xfer) begin
        o_mult_a <= i_req_a[xfer_id*IN_WIDTH_I +: IN_WIDTH_I];
        o_mult_b <= i_req_b[xfer_id*IN_WIDTH_I +: IN_WIDTH_I];
        o_mult_c <= i_req_c[xfer_id*IN_WIDTH_II +: IN_WIDTH_II];
        o_mult_d <= i_req_d[xfer_id*IN_WIDTH_II +: IN_WIDTH_II];
      end
    end
  end

  assign o_mult_valid = iss_tag_q.vld;

  // Tag enters alongside the operand strobe; its last stage lines up with the multiplier result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < MULT_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= iss_tag_q;
      for (int k = 1; k < MULT_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_out = tag_q[MULT_LATENCY-1];
  assign rsp_hit = tag_out.vld & i_mult_valid;

  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[tag_out.id[ID_WIDTH-1:0]] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= '0;
      o_rsp_r     <= '0;
      o_rsp_im    <= '0;
      o_rsp_last  <= 1'b0;
      o_err_sync  <= 1'b0;
    end else begin
      o_rsp_valid <= rsp_hit ? rsp_onehot : '0;
      if (rsp_hit) begin
        o_rsp_r    <= i_mult_r;
        o_rsp_im   <= i_mult_im;
        o_rsp_last <= tag_out.last;
      end
      if (tag_out.vld != i_mult_valid) o_err_sync <= 1'b1;
    end
  end

`ifdef CMULT_SCHED_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (xfer && xfer_id == ID_WIDTH'(k) && o_grant_cnt[k*16 +: 16] != 16'hFFFF)
          o_grant_cnt[k*16 +: 16] <= o_grant_cnt[k*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_comp_mult_sched.sv
// Directed bench for comp_mult_sched with a 4-cycle complex multiplier model on the shared port.
module tb_comp_mult_sched;

  localparam int N = 4;
  localparam int W = 18;
  localparam int L = 4;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [N-1:0]     i_req_valid = '0;
  logic [N-1:0]     i_req_last = '0;
  logic [N*W-1:0]   i_req_a = '0, i_req_b = '0, i_req_c = '0, i_req_d = '0;
  logic [N-1:0]     o_req_ready;
  logic [W-1:0]     o_mult_a, o_mult_b, o_mult_c, o_mult_d;
  logic             o_mult_valid;
  logic [W-1:0]     i_mult_r, i_mult_im;
  logic             i_mult_valid;
  logic [N-1:0]     o_rsp_valid;
  logic [W-1:0]     o_rsp_r, o_rsp_im;
  logic             o_rsp_last;
  logic             o_err_sync;
`ifdef CMULT_SCHED_STATS_EN
  logic [N*16-1:0]  o_grant_cnt;
`endif

  comp_mult_sched dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .i_req_c     (i_req_c),
    .i_req_d     (i_req_d),
    .o_req_ready (o_req_ready),
    .o_mult_a    (o_mult_a),
    .o_mult_b    (o_mult_b),
    .o_mult_c    (o_mult_c),
    .o_mult_d    (o_mult_d),
    .o_mult_valid(o_mult_valid),
    .i_mult_r    (i_mult_r),
    .i_mult_im   (i_mult_im),
    .i_mult_valid(i_mult_valid),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_r     (o_rsp_r),
    .o_rsp_im    (o_rsp_im),
    .o_rsp_last  (o_rsp_last),
    .o_err_sync  (o_err_sync)
`ifdef CMULT_SCHED_STATS_EN
    ,
    .o_grant_cnt (o_grant_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Complex multiplier model: r = a*c - b*d, im = a*d + b*c, fixed latency L, flushed by reset.
  function automatic logic [W-1:0] cm_re(input logic [W-1:0] a, b, c, d);
    logic signed [2*W+1:0] t;
    t = $signed(a) * $signed(c) - $signed(b) * $signed(d);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] cm_im(input logic [W-1:0] a, b, c, d);
    logic signed [2*W+1:0] t;
    t = $signed(a) * $signed(d) + $signed(b) * $signed(c);
    return t[W-1:0];
  endfunction

  logic         m_vld [L];
  logic [W-1:0] m_r   [L];
  logic [W-1:0] m_im  [L];
  logic         inj = 1'b0;

  always @(posedge i_clk or negedge i_rst_n) begin
    cyc <= cyc + 1;
    if (!i_rst_n) begin
      for (int k = 0; k < L; k++) begin
        m_vld[k] <= 1'b0;
        m_r[k]   <= '0;
        m_im[k]  <= '0;
      end
    end else begin
      m_vld[0] <= o_mult_valid;
      m_r[0]   <= cm_re(o_mult_a, o_mult_b, o_mult_c, o_mult_d);
      m_im[0]  <= cm_im(o_mult_a, o_mult_b, o_mult_c, o_mult_d);
      for (int k = 1; k < L; k++) begin
        m_vld[k] <= m_vld[k-1];
        m_r[k]   <= m_r[k-1];
        m_im[k]  <= m_im[k-1];
      end
    end
  end

  assign i_mult_valid = m_vld[L-1] | inj;
  assign i_mult_r     = m_r[L-1];
  assign i_mult_im    = m_im[L-1];

  typedef struct {
    int           id;
    logic [W-1:0] r;
    logic [W-1:0] im;
    logic         last;
    int           cyc;
  } rsp_t;

  rsp_t rsp_q[$];

  always @(negedge i_clk) begin
    if (i_rst_n && o_rsp_valid != '0) begin
      rsp_t e;
      chk("rsp_onehot", 64'($countones(o_rsp_valid)), 64'd1);
      e.id = 0;
      for (int k = 0; k < N; k++) if (o_rsp_valid[k]) e.id = k;
      e.r    = o_rsp_r;
      e.im   = o_rsp_im;
      e.last = o_rsp_last;
      e.cyc  = cyc;
      rsp_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, b, c, d);
    i_req_a[k*W +: W] = a;
    i_req_b[k*W +: W] = b;
    i_req_c[k*W +: W] = c;
    i_req_d[k*W +: W] = d;
  endtask

  task automatic do_reset();
    i_req_valid = '0;
    i_req_last  = '0;
    inj         = 1'b0;
    i_rst_n     = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    rsp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Reset state
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_mult_valid", 64'(o_mult_valid), 64'd0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("rst_err", 64'(o_err_sync), 64'd0);
    chk("rst_rsp_r", 64'(o_rsp_r), 64'd0);
    chk("rst_ready", 64'(o_req_ready), 64'd0);

    // 1: single request from req1
    do_reset();
    set_req(1, 18'd3, 18'd4, 18'd1, 18'd2);
    i_req_valid = 4'b0010;
    i_req_last  = 4'b0010;
    @(negedge i_clk);
    chk("t1_ready", 64'(o_req_ready), 64'h2);
    step();
    i_req_valid = '0;
    n = 1;
    chk("t1_mult_valid", 64'(o_mult_valid), 64'd1);
    chk("t1_mult_abcd", {o_mult_a, o_mult_b, o_mult_c, o_mult_d},
        {18'd3, 18'd4, 18'd1, 18'd2});
    step();
    n++;
    chk("t1_mult_drop", 64'(o_mult_valid), 64'd0);
    chk("t1_mult_hold", 64'(o_mult_a), 64'd3);
    while (o_rsp_valid == '0 && n < 20) begin
      step();
      n++;
    end
    chk("t1_latency", 64'(n), 64'd6);
    chk("t1_rsp_valid", 64'(o_rsp_valid), 64'h2);
    chk("t1_rsp_r", 64'(o_rsp_r), 64'h3FFFB);
    chk("t1_rsp_im", 64'(o_rsp_im), 64'd10);
    chk("t1_rsp_last", 64'(o_rsp_last), 64'd1);

    // 2: all four valid, single beats -> strict rotation at full rate
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 18'(k + 1), 18'(k), 18'd1, 18'd0);
    i_req_valid = 4'b1111;
    i_req_last  = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      chk("t2_rr_gnt", 64'(o_req_ready), 64'(1 << (i % 4)));
      step();
    end
    i_req_valid = '0;
    repeat (10) step();
    chk("t2_rsp_count", 64'(rsp_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
      chk("t2_rsp_id", 64'(rsp_q[i].id), 64'(i % 4));
      chk("t2_rsp_r", 64'(rsp_q[i].r), 64'((i % 4) + 1));
      chk("t2_rsp_im", 64'(rsp_q[i].im), 64'(i % 4));
      chk("t2_full_rate", 64'(rsp_q[i].cyc - rsp_q[0].cyc), 64'(i));
    end
    chk("t2_err", 64'(o_err_sync), 64'd0);

    // 3: req2 burst of 3 with two bubbles while req0 waits
    do_reset();
    set_req(2, 18'd7, 18'd0, 18'd1, 18'd0);
    set_req(0, 18'd5, 18'd0, 18'd1, 18'd0);
    i_req_valid = 4'b0100;
    i_req_last  = 4'b0000;
    @(negedge i_clk);
    chk("t3_beat1_ready", 64'(o_req_ready), 64'h4);
    step();
    i_req_valid = 4'b0101;
    @(negedge i_clk);
    chk("t3_beat2_ready", 64'(o_req_ready), 64'h4);
    step();
    i_req_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("t3_bubble_ready", 64'(o_req_ready), 64'h4);
      step();
      chk("t3_bubble_issue", 64'(o_mult_valid), 64'd0);
    end
    i_req_valid = 4'b0101;
    i_req_last  = 4'b0100;
    @(negedge i_clk);
    chk("t3_beat3_ready", 64'(o_req_ready), 64'h4);
    step();
    i_req_valid = 4'b0001;
    i_req_last  = 4'b0001;
    @(negedge i_clk);
    chk("t3_req0_ready", 64'(o_req_ready), 64'h1);
    step();
    i_req_valid = '0;
    repeat (10) step();
    chk("t3_rsp_count", 64'(rsp_q.size()), 64'd4);
    if (rsp_q.size() == 4) begin
      chk("t3_order", {32'(rsp_q[0].id), 8'(rsp_q[1].id), 8'(rsp_q[2].id), 8'(rsp_q[3].id)},
          {32'd2, 8'd2, 8'd2, 8'd0});
      chk("t3_last", {rsp_q[0].last, rsp_q[1].last, rsp_q[2].last, rsp_q[3].last}, 64'b0011);
      chk("t3_r", {rsp_q[0].r, rsp_q[3].r}, {18'd7, 18'd5});
    end

    // 4: result strobe with empty tag pipe
    do_reset();
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("t4_err_set", 64'(o_err_sync), 64'd1);
    repeat (5) step();
    chk("t4_err_sticky", 64'(o_err_sync), 64'd1);
    chk("t4_no_rsp", 64'(rsp_q.size()), 64'd0);

    // 5: reset with three results in flight
    rsp_q.delete();
    for (int k = 0; k < N; k++) set_req(k, 18'(k + 9), 18'd1, 18'd1, 18'd1);
    i_req_valid = 4'b1110;
    i_req_last  = 4'b1110;
    repeat (3) step();
    i_req_valid = '0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("t5_rst_mult_valid", 64'(o_mult_valid), 64'd0);
    chk("t5_rst_mult_a", 64'(o_mult_a), 64'd0);
    chk("t5_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("t5_rst_err", 64'(o_err_sync), 64'd0);
    step();
    i_rst_n = 1'b1;
    repeat (12) step();
    chk("t5_no_rsp", 64'(rsp_q.size()), 64'd0);
    i_req_valid = 4'b1111;
    i_req_last  = 4'b1111;
    @(negedge i_clk);
    chk("t5_next_gnt", 64'(o_req_ready), 64'h1);
    step();
    i_req_valid = '0;

`ifdef CMULT_SCHED_STATS_EN
    // 6: grant counters saturate
    do_reset();
    i_req_valid = 4'b1000;
    i_req_last  = 4'b1000;
    repeat (70000) step();
    i_req_valid = '0;
    step();
    chk("t6_cnt3", 64'(o_grant_cnt[63:48]), 64'hFFFF);
    chk("t6_cnt_others", 64'(o_grant_cnt[47:0]), 64'd0);
    repeat (10) step();
    rsp_q.delete();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
